video_mode_switcher: RTL and testbench

Sequences runtime video-mode changes for the sync/DE timing generator. It accepts a new `VideoMode` over a valid/ready handshake and blanks the output. It applies the new mode only on a frame boundary, so the timing generator never sees a mid-frame parameter change. It holds blanking for a settle period before releasing the picture. It sits between the mode-select/config logic and the timing generator, and drives that generator's `videoMode` input.

---
 rtl/video_mode_switcher.sv | 145 ++++++++++++++
 tb/tb_video_mode_switcher.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_mode_switcher.sv
// video_mode_switcher: sequences runtime video-mode changes for the sync/DE timing generator.
// A new mode is accepted over req_valid/req_ready, the picture is blanked, the mode is
// swapped on a frame boundary, and blanking is held for a number of new-mode frames.
// VideoMode encoding (24 bits): [23:12] = h_total, [11:0] = v_total.
module video_mode_switcher #(
    parameter int PRE_BLANK_FRAMES = 1,
    parameter int SETTLE_FRAMES    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [23:0] init_mode,
    input  logic [23:0] req_mode,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [11:0] counterX,
    input  logic [11:0] counterY,
    output logic [23:0] active_mode,
    output logic        blank,
    output logic        busy,
    output logic        switch_done,
    output logic        frame_start
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PRE_BLANK = 2'd1,
        S_SETTLE    = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    // Frame-end counts at which the swap and the release happen.
    localparam logic [7:0] C_PRE_LAST    = 8'(PRE_BLANK_FRAMES - 1);
    localparam logic [7:0] C_SETTLE_LAST = 8'((SETTLE_FRAMES > 0) ? (SETTLE_FRAMES - 1) : 0);

    state_t      r_state;
    state_t      w_state_next;
    logic [23:0] r_pending;
    logic [23:0] w_pending_next;
    logic [7:0]  r_frame_cnt;
    logic [7:0]  w_frame_cnt_next;
    logic [23:0] r_active_mode;
    logic [23:0] w_active_next;
    logic        r_blank;
    logic        r_busy;
    logic        r_req_ready;
    logic        r_switch_done;
    logic        r_frame_start;
    logic        w_same_mode_done;
    logic        w_accept;
    logic [11:0] w_h_last;
    logic [11:0] w_v_last;
    logic        w_frame_end;

    // Frame end is judged against the mode currently driving the generator; >= keeps the
    // sequence moving even when the counters are out of range for that mode.
    always_comb begin
        w_h_last    = r_active_mode[23:12] - 12'd1;
        w_v_last    = r_active_mode[11:0] - 12'd1;
        w_frame_end = (counterX >= w_h_last) && (counterY >= w_v_last);
        w_accept    = req_valid && r_req_ready;
    end

    // Next-state, pending mode, frame counting and mode swap.
    always_comb begin
        w_state_next     = r_state;
        w_pending_next   = r_pending;
        w_frame_cnt_next = r_frame_cnt;
        w_active_next    = r_active_mode;
        w_same_mode_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (req_mode == r_active_mode) begin
                        w_same_mode_done = 1'b1;
                    end else begin
                        w_pending_next   = req_mode;
                        w_frame_cnt_next = 8'd0;
                        w_state_next     = S_PRE_BLANK;
                    end
                end
            end
            S_PRE_BLANK: begin
                if (w_frame_end) begin
                    if (r_frame_cnt == C_PRE_LAST) begin
                        w_active_next    = r_pending;
                        w_frame_cnt_next = 8'd0;
                        w_state_next     = (SETTLE_FRAMES == 0) ? S_DONE : S_SETTLE;
                    end else begin
                        w_frame_cnt_next = r_frame_cnt + 8'd1;
                    end
                end
            end
            S_SETTLE: begin
                if (w_frame_end) begin
                    if (r_frame_cnt == C_SETTLE_LAST) begin
                        w_frame_cnt_next = 8'd0;
                        w_state_next     = S_DONE;
                    end else begin
                        w_frame_cnt_next = r_frame_cnt + 8'd1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Control state and registered outputs; outputs are derived from the next state so
    // they line up with the state they describe.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_frame_cnt   <= 8'd0;
            r_active_mode <= init_mode;
            r_blank       <= 1'b0;
            r_busy        <= 1'b0;
            r_req_ready   <= 1'b1;
            r_switch_done <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_frame_cnt   <= w_frame_cnt_next;
            r_active_mode <= w_active_next;
            r_blank       <= (w_state_next == S_PRE_BLANK) || (w_state_next == S_SETTLE);
            r_busy        <= (w_state_next == S_PRE_BLANK) || (w_state_next == S_SETTLE);
            r_req_ready   <= (w_state_next == S_IDLE);
            r_switch_done <= (w_state_next == S_DONE) || w_same_mode_done;
            r_frame_start <= w_frame_end;
        end
    end

    // Pending mode is plain data; it is only read after being loaded on accept.
    always_ff @(posedge clock) begin
        r_pending <= w_pending_next;
    end

    assign active_mode = r_active_mode;
    assign blank       = r_blank;
    assign busy        = r_busy;
    assign req_ready   = r_req_ready;
    assign switch_done = r_switch_done;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_video_mode_switcher.sv
// Testbench for video_mode_switcher: drives a simple timing-generator counter model that
// follows the active mode, and checks every output each cycle against a frame-counting model.
module tb_video_mode_switcher;

    localparam logic [23:0] MODE_A = {12'd10, 12'd4};
    localparam logic [23:0] MODE_B = {12'd12, 12'd5};
    localparam logic [23:0] MODE_C = {12'd8,  12'd3};
    localparam int PRE    = 1;
    localparam int SETTLE = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [23:0] init_mode;
    logic [23:0] req_mode;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] counterX;
    logic [11:0] counterY;
    logic [23:0] active_mode;
    logic        blank;
    logic        busy;
    logic        switch_done;
    logic        frame_start;

    always #5 clock = ~clock;

    video_mode_switcher #(
        .PRE_BLANK_FRAMES(PRE),
        .SETTLE_FRAMES   (SETTLE)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .init_mode  (init_mode),
        .req_mode   (req_mode),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .counterX   (counterX),
        .counterY   (counterY),
        .active_mode(active_mode),
        .blank      (blank),
        .busy       (busy),
        .switch_done(switch_done),
        .frame_start(frame_start)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Model: mode in force, whether a switch is in progress, and frames still to go.
    logic [23:0] m_active;
    logic [23:0] m_pend;
    logic        m_sw;
    logic        m_done;
    logic        m_ready;
    logic        m_fs;
    int          m_pre_left;
    int          m_settle_left;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    task automatic model_step(input logic fe);
        logic done_n;
        done_n = 1'b0;
        if (!reset_n) begin
            m_active = init_mode;
            m_sw     = 1'b0;
            m_fs     = 1'b0;
            m_ready  = 1'b1;
        end else begin
            m_fs = fe;
            if (m_sw) begin
                if (fe) begin
                    if (m_pre_left > 0) begin
                        m_pre_left--;
                        if (m_pre_left == 0) m_active = m_pend;
                    end else begin
                        m_settle_left--;
                    end
                    if (m_pre_left == 0 && m_settle_left == 0) begin
                        m_sw   = 1'b0;
                        done_n = 1'b1;
                    end
                end
                m_ready = !m_sw && !done_n;
            end else if (m_ready && req_valid) begin
                if (req_mode == m_active) begin
                    done_n = 1'b1;
                end else begin
                    m_sw          = 1'b1;
                    m_pend        = req_mode;
                    m_pre_left    = PRE;
                    m_settle_left = SETTLE;
                end
                m_ready = !m_sw;
            end else begin
                m_ready = 1'b1;
            end
        end
        m_done = done_n;
    endtask

    task automatic compare_all();
        chk("active_mode", int'(active_mode), int'(m_active));
        chk("blank",       int'(blank),       int'(m_sw));
        chk("busy",        int'(busy),        int'(m_sw));
        chk("req_ready",   int'(req_ready),   int'(m_ready));
        chk("switch_done", int'(switch_done), int'(m_done));
        chk("frame_start", int'(frame_start), int'(m_fs));
    endtask

    // One clock: the generator advances using the mode in force before the edge.
    task automatic tick();
        logic fe;
        int   hl;
        int   vl;
        hl = int'(m_active[23:12]) - 1;
        vl = int'(m_active[11:0]) - 1;
        fe = (int'(counterX) >= hl) && (int'(counterY) >= vl);
        @(posedge clock);
        model_step(fe);
        #1;
        if (fe) begin
            counterX = 12'd0;
            counterY = 12'd0;
        end else if (int'(counterX) >= hl) begin
            counterX = 12'd0;
            counterY = counterY + 12'd1;
        end else begin
            counterX = counterX + 12'd1;
        end
        compare_all();
    endtask

    task automatic drain_to_idle(input string name);
        int k;
        k = 0;
        while (!(req_ready && !busy && !switch_done) && k < 1000) begin
            tick();
            k++;
        end
        if (k >= 1000) timeout(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int first;
        int period;
        int k;
        int first_b;
        int blank_cnt;
        int done_tick;
        int done_cnt;
        logic saw_a;

        reset_n   = 1'b0;
        init_mode = MODE_A;
        req_mode  = MODE_A;
        req_valid = 1'b0;
        counterX  = 12'd0;
        counterY  = 12'd0;
        m_active  = MODE_A;
        m_pend    = MODE_A;
        m_sw      = 1'b0;
        m_done    = 1'b0;
        m_ready   = 1'b1;
        m_fs      = 1'b0;
        m_pre_left    = 0;
        m_settle_left = 0;

        // Reset state
        repeat (3) tick();
        chk("reset_active_mode", int'(active_mode), int'(MODE_A));
        chk("reset_req_ready",   int'(req_ready),   1);
        chk("reset_blank",       int'(blank),       0);
        chk("reset_busy",        int'(busy),        0);
        chk("reset_frame_start", int'(frame_start), 0);
        reset_n = 1'b1;

        // frame_start period under mode A
        first  = -1;
        period = 0;
        for (int i = 0; i < 200 && period == 0; i++) begin
            tick();
            if (frame_start) begin
                if (first < 0) first = i;
                else period = i - first;
            end
        end
        chk("frame_start_period", period, 40);

        // Switch A -> B, requested at (3,1) of A
        k = 0;
        while (!(counterX == 12'd3 && counterY == 12'd1) && k < 100) begin
            tick();
            k++;
        end
        if (k >= 100) timeout("align_3_1");
        req_mode  = MODE_B;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("blank_after_accept", int'(blank), 1);
        chk("ready_after_accept", int'(req_ready), 0);
        first_b   = 0;
        blank_cnt = 1;
        done_tick = 0;
        done_cnt  = 0;
        k = 1;
        while (done_tick == 0 && k < 400) begin
            tick();
            k++;
            if (blank) blank_cnt++;
            if (active_mode == MODE_B && first_b == 0) first_b = k;
            if (switch_done) begin
                done_cnt++;
                done_tick = k;
            end
        end
        tick();
        if (switch_done) done_cnt++;
        chk("first_B_tick", first_b, 27);
        chk("blank_cycles", blank_cnt, 147 - 1);
        chk("done_tick", done_tick, 147);
        chk("done_pulses", done_cnt, 1);
        chk("ready_after_done", int'(req_ready), 1);

        // Request equal to the active mode
        req_mode  = MODE_B;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("same_done", int'(switch_done), 1);
        chk("same_blank", int'(blank), 0);
        chk("same_busy", int'(busy), 0);
        tick();
        chk("same_done_end", int'(switch_done), 0);

        // Switch to A while C is held valid; C waits for the next idle cycle
        req_mode  = MODE_A;
        req_valid = 1'b1;
        tick();
        chk("hold_busy", int'(busy), 1);
        req_mode = MODE_C;
        saw_a = 1'b0;
        k = 0;
        while (active_mode != MODE_C && k < 1000) begin
            tick();
            k++;
            if (active_mode == MODE_A) saw_a = 1'b1;
        end
        req_valid = 1'b0;
        chk("A_before_C", int'(saw_a), 1);
        chk("C_applied", int'(active_mode), int'(MODE_C));
        drain_to_idle("drain_C");

        // Reset during SETTLE
        req_mode  = MODE_B;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        k = 0;
        while (active_mode != MODE_B && k < 500) begin
            tick();
            k++;
        end
        if (k >= 500) timeout("reach_settle");
        repeat (5) tick();
        reset_n = 1'b0;
        tick();
        chk("rst_mid_active", int'(active_mode), int'(MODE_A));
        chk("rst_mid_blank", int'(blank), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_done", int'(switch_done), 0);
        reset_n = 1'b1;
        tick();
        chk("rst_mid_done_after", int'(switch_done), 0);
        chk("rst_mid_ready_after", int'(req_ready), 1);

        // Out-of-range counters while in PRE_BLANK count as a frame end
        req_mode  = MODE_B;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        counterX = 12'd15;
        counterY = 12'd7;
        tick();
        chk("oor_switch", int'(active_mode), int'(MODE_B));
        chk("oor_blank", int'(blank), 1);
        drain_to_idle("drain_oor");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
